mem_port_arbiter: RTL

- Shares one single-port 32-bit memory between the instruction-fetch requester and the load/store (data) requester.
- Decodes the 4-bit memory-op code produced by control_unit (mem_write) into byte enables and write-data lane replication.
- Sequences the memory bus handshake and returns aligned, sign/zero-extended load data.
- Sits between core datapath and memory; the core stalls while its requester's ready is low.

---
 rtl/riscv_mem_pkg.sv | 53 +++++
 rtl/mem_lane_align.sv | 63 ++++++
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared memory-op codes, FSM and owner encodings for the memory port.
// Also holds small op-classification helpers used by the arbiter and aligner.
package riscv_mem_pkg;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_SW   = 4'd1;
  localparam logic [3:0] MEM_SH   = 4'd2;
  localparam logic [3:0] MEM_SB   = 4'd3;
  localparam logic [3:0] MEM_LW   = 4'd4;
  localparam logic [3:0] MEM_LH   = 4'd5;
  localparam logic [3:0] MEM_LB   = 4'd6;
  localparam logic [3:0] MEM_LBU  = 4'd7;
  localparam logic [3:0] MEM_LHU  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  function automatic logic op_is_dreq(input logic [3:0] op);
    return (op >= MEM_SW) && (op <= MEM_LHU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == MEM_SW) || (op == MEM_SH) || (op == MEM_SB);
  endfunction

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= MEM_LW) && (op <= MEM_LHU);
  endfunction

  function automatic logic op_misaligned(
    input logic [3:0] op,
    input logic [1:0] lo
  );
    logic m;
    m = 1'b0;
    case (op)
      MEM_SW, MEM_LW:          m = (lo != 2'b00);
      MEM_SH, MEM_LH, MEM_LHU: m = lo[0];
      default:                 m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / lane replication and
// load-data extraction with sign or zero extension.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [3:0]  mem_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] shifted;

  assign is_byte = (mem_op == MEM_SB) || (mem_op == MEM_LB) ||
                   (mem_op == MEM_LBU);
  assign is_half = (mem_op == MEM_SH) || (mem_op == MEM_LH) ||
                   (mem_op == MEM_LHU);
  assign is_word = (mem_op == MEM_SW) || (mem_op == MEM_LW);

  assign shifted  = rdata >> {addr_lo, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    unique case (1'b1)
      is_byte: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      is_half: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      is_word: begin
        be        = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    load_data = '0;
    case (mem_op)
      MEM_LW:  load_data = rdata;
      MEM_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: load_data = {16'h0000, half_sel};
      MEM_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: load_data = {24'h000000, byte_sel};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// with a starvation guard so fetch eventually wins against busy data traffic.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic          if_valid,
  output logic [31:0]   if_rdata,
  input  logic [3:0]    d_mem_op,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ready,
  output logic          d_valid,
  output logic [31:0]   d_rdata,
  output logic          d_misaligned,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);
  import riscv_mem_pkg::*;

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [3:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          mem_req_q, mem_req_d;
  logic          if_valid_q, if_valid_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic          d_valid_q, d_valid_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          d_mis_q, d_mis_d;

  logic          d_req;
  logic          fetch_win;
  logic          data_win;
  logic          in_idle;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [31:0]   load_data;

  mem_lane_align u_align (
    .mem_op    (op_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .load_data (load_data)
  );

  assign d_req     = op_is_dreq(d_mem_op);
  assign fetch_win = if_req && (!d_req || (starve_q == LIMIT));
  assign data_win  = d_req && !fetch_win;
  assign in_idle   = (state_q == S_IDLE) && !reset;

  assign if_ready = in_idle && fetch_win;
  assign d_ready  = in_idle && data_win;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    starve_d   = starve_q;
    mem_req_d  = mem_req_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    d_mis_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!if_req) starve_d = '0;
        if (fetch_win) begin
          // Fetch is issued as a full-word read.
          owner_d   = OWN_IF;
          op_d      = MEM_LW;
          addr_d    = if_addr;
          wdata_d   = '0;
          starve_d  = '0;
          mem_req_d = 1'b1;
          state_d   = S_ISSUE;
        end else if (data_win) begin
          owner_d = OWN_D;
          op_d    = d_mem_op;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          if (if_req && (starve_q != LIMIT)) starve_d = starve_q + CW'(1);
          if (op_misaligned(d_mem_op, d_addr[1:0])) begin
            d_valid_d = 1'b1;
            d_mis_d   = 1'b1;
            d_rdata_d = '0;
            state_d   = S_ERR;
          end else begin
            mem_req_d = 1'b1;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_IDLE;
          if (owner_q == OWN_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_valid_d = 1'b1;
            d_rdata_d = op_is_load(op_q) ? load_data : '0;
          end
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IF;
      op_q       <= MEM_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      starve_q   <= '0;
      mem_req_q  <= 1'b0;
      if_valid_q <= 1'b0;
      if_rdata_q <= '0;
      d_valid_q  <= 1'b0;
      d_rdata_q  <= '0;
      d_mis_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      starve_q   <= starve_d;
      mem_req_q  <= mem_req_d;
      if_valid_q <= if_valid_d;
      if_rdata_q <= if_rdata_d;
      d_valid_q  <= d_valid_d;
      d_rdata_q  <= d_rdata_d;
      d_mis_q    <= d_mis_d;
    end
  end

  assign if_valid     = if_valid_q;
  assign if_rdata     = if_rdata_q;
  assign d_valid      = d_valid_q;
  assign d_rdata      = d_rdata_q;
  assign d_misaligned = d_mis_q;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_req_q && (owner_q == OWN_D) && op_is_store(op_q);
  assign mem_be    = mem_req_q ? be : 4'b0000;
  assign mem_addr  = mem_req_q ? {addr_q[AW-1:2], 2'b00} : '0;
  assign mem_wdata = mem_we ? wdata_rep : '0;

endmodule
